// File: rtl/ntt_slot_scheduler_pkg.sv
// Shared types and constants for the NTT multi-slot coefficient scheduler.
package ntt_slot_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEED,
    RUN,
    UNLOAD
  } state_t;

  // Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  // Reset seed, also substituted for an all-zero seed (which would lock the LFSR)
  localparam logic [15:0] SEED_SUB  = 16'hACE1;

  // Address width for an n-entry space; a single entry still needs one bit
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Address width spanning every slot of the coefficient RAM
  function automatic int ram_addr_w(input int slots, input int depth);
    return addr_w(slots * depth);
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: port A synchronous read (1-cycle latency), port B write.
// Read-during-write to the same address returns the old contents.
module dual_port_ram
  import ntt_slot_scheduler_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 16,
  localparam int AW    = addr_w(LENGTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    a_addr,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata
);

  logic [WIDTH-1:0] mem [LENGTH];

  // Port A: registered read
  always_ff @(posedge clk) begin
    a_rdata <= mem[a_addr];
  end

  // Port B: write
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
  end

endmodule

// File: rtl/ntt_slot_scheduler.sv
// Multi-slot coefficient scheduler: loads polynomial slots plus a per-slot seed,
// launches the NTT core on one slot while driving an LFSR twiddle randomiser,
// and streams a slot back out through a two-entry skid buffer.
module ntt_slot_scheduler
  import ntt_slot_scheduler_pkg::*;
#(
  parameter int DW     = 132,
  parameter int DEPTH  = 64,
  parameter int SLOTS  = 4,
  parameter int SEED_W = 16,
  parameter int ZW     = 9,
  localparam int AW    = addr_w(DEPTH),
  localparam int SLW   = addr_w(SLOTS),
  localparam int RAW   = ram_addr_w(SLOTS, DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SLW-1:0] slot_sel,
  input  logic [2:0]     mode,
  input  logic [DW-1:0]  in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           start,
  input  logic           unload,
  output logic           busy,
  output logic           core_start,
  output logic [2:0]     core_mode,
  input  logic           core_done,
  input  logic [AW-1:0]  core_raddr,
  output logic [DW-1:0]  core_rdata,
  input  logic           core_we,
  input  logic [AW-1:0]  core_waddr,
  input  logic [DW-1:0]  core_wdata,
  output logic [ZW-1:0]  rnd_addr,
  output logic           rnd_phase,
  output logic [DW-1:0]  out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           done
);

  state_t              state;
  logic [SLW-1:0]      cur_slot;
  logic [AW-1:0]       cnt;
  logic [SEED_W-1:0]   seed_reg [SLOTS];
  logic [SEED_W-1:0]   lfsr;
  logic [1:0]          ph_cnt;

  logic [RAW-1:0]      ram_raddr;
  logic [RAW-1:0]      ram_waddr;
  logic [DW-1:0]       ram_wdata;
  logic [DW-1:0]       ram_rdata;
  logic                ram_we;

  logic                core_rd_p1;
  logic [DW-1:0]       core_rdata_hold;

  logic [AW:0]         rd_cnt;
  logic                rd_inflight_p1;
  logic                rd_issue;
  logic [2:0]          occ;
  logic [DW-1:0]       skid [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          skid_cnt;
  logic [AW-1:0]       out_idx;
  logic                out_fire;

  function automatic logic [RAW-1:0] slot_addr(input logic [SLW-1:0] s, input logic [AW-1:0] w);
    return (RAW'(s) << AW) | RAW'(w);
  endfunction

  function automatic logic [SEED_W-1:0] lfsr_next(input logic [SEED_W-1:0] v);
    return v[0] ? ((v >> 1) ^ SEED_W'(LFSR_MASK)) : (v >> 1);
  endfunction

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD) || (state == SEED);
  assign rnd_addr  = lfsr[ZW-1:0];
  assign out_valid = (skid_cnt != 2'd0);
  assign out_data  = skid[rd_ptr];
  assign out_last  = out_valid && (out_idx == AW'(DEPTH - 1));
  assign out_fire  = out_valid && out_ready;
  // Core sees live RAM data the cycle after a RUN read, otherwise the last such word
  assign core_rdata = core_rd_p1 ? ram_rdata : core_rdata_hold;

  // Keep at most two words between RAM and stream: buffered + in flight - leaving
  assign occ      = {1'b0, skid_cnt} + {2'b00, rd_inflight_p1} - {2'b00, out_fire};
  assign rd_issue = (state == UNLOAD) && !rd_cnt[AW] && (occ < 3'd2);

  // Port A serves the core during RUN and the unload reader otherwise
  always_comb begin
    ram_raddr = slot_addr(cur_slot, rd_cnt[AW-1:0]);
    if (state == RUN) ram_raddr = slot_addr(cur_slot, core_raddr);
  end

  // Port B takes load-stream words or core write-backs
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = slot_addr(cur_slot, cnt);
    ram_wdata = in_data;
    if (state == IDLE) begin
      ram_we    = in_valid;
      ram_waddr = slot_addr(slot_sel, AW'(0));
    end else if (state == LOAD) begin
      ram_we    = in_valid;
    end else if (state == RUN) begin
      ram_we    = core_we;
      ram_waddr = slot_addr(cur_slot, core_waddr);
      ram_wdata = core_wdata;
    end
  end

  dual_port_ram #(
    .WIDTH  (DW),
    .LENGTH (SLOTS * DEPTH)
  ) u_ram (
    .clk     (clk),
    .a_addr  (ram_raddr),
    .a_rdata (ram_rdata),
    .b_we    (ram_we),
    .b_addr  (ram_waddr),
    .b_wdata (ram_wdata)
  );

  // Command FSM, seed store, LFSR and phase generator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur_slot   <= '0;
      cnt        <= '0;
      core_start <= 1'b0;
      core_mode  <= '0;
      done       <= 1'b0;
      lfsr       <= SEED_W'(SEED_SUB);
      ph_cnt     <= 2'd0;
      rnd_phase  <= 1'b1;
      for (int s = 0; s < SLOTS; s++) seed_reg[s] <= SEED_W'(SEED_SUB);
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cur_slot <= slot_sel;
            cnt      <= AW'(1);
            state    <= (DEPTH == 1) ? SEED : LOAD;
          end else if (start) begin
            cur_slot   <= slot_sel;
            core_mode  <= mode;
            lfsr       <= seed_reg[slot_sel];
            core_start <= 1'b1;
            ph_cnt     <= 2'd0;
            rnd_phase  <= 1'b1;
            state      <= RUN;
          end else if (unload) begin
            cur_slot <= slot_sel;
            state    <= UNLOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(DEPTH - 1)) state <= SEED;
          end
        end
        SEED: begin
          if (in_valid) begin
            seed_reg[cur_slot] <= (in_data[SEED_W-1:0] == '0) ? SEED_W'(SEED_SUB)
                                                              : in_data[SEED_W-1:0];
            state <= IDLE;
          end
        end
        RUN: begin
          if (core_done) begin
            done      <= 1'b1;
            ph_cnt    <= 2'd0;
            rnd_phase <= 1'b1;
            state     <= IDLE;
          end else begin
            lfsr   <= lfsr_next(lfsr);
            ph_cnt <= ph_cnt + 2'd1;
            if (ph_cnt == 2'd3) rnd_phase <= ~rnd_phase;
          end
        end
        UNLOAD: begin
          if (out_fire && out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Core read-data hold register: captures each RUN read result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rd_p1      <= 1'b0;
      core_rdata_hold <= '0;
    end else begin
      core_rd_p1 <= (state == RUN);
      if (core_rd_p1) core_rdata_hold <= ram_rdata;
    end
  end

  // Unload reader: issue RAM reads, stage returns in the skid buffer, pop on transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt         <= '0;
      rd_inflight_p1 <= 1'b0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      skid_cnt       <= 2'd0;
      out_idx        <= '0;
      skid[0]        <= '0;
      skid[1]        <= '0;
    end else if (state != UNLOAD) begin
      rd_cnt         <= '0;
      rd_inflight_p1 <= 1'b0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      skid_cnt       <= 2'd0;
      out_idx        <= '0;
    end else begin
      rd_inflight_p1 <= rd_issue;
      if (rd_issue) rd_cnt <= rd_cnt + (AW+1)'(1);
      if (rd_inflight_p1) begin
        skid[wr_ptr] <= ram_rdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (out_fire) begin
        rd_ptr  <= ~rd_ptr;
        out_idx <= out_idx + AW'(1);
      end
      skid_cnt <= skid_cnt + {1'b0, rd_inflight_p1} - {1'b0, out_fire};
    end
  end

endmodule
